// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: register-index width, forwarding-select
// codes and the memory-wait FSM state encoding.
package pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  // Operand source selects for the ID-stage forwarding muxes
  localparam logic [FWD_W-1:0] FWD_REG    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXALU  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEMALU = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEMLD  = 2'b11;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

endpackage : pipe_pkg

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
//   master : datapath side (drives stage info, receives control)
//   slave  : controller side
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  // ID-stage operands
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_flushed;
  // EX-stage producer
  logic             ewreg;
  logic             em2reg;
  logic [REG_W-1:0] ern;
  // MEM-stage producer
  logic             mwreg;
  logic             mm2reg;
  logic [REG_W-1:0] mrn;
  // Control flow and data memory
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  // Controller outputs
  logic             wpcir;
  logic             flush;
  logic             bubble;
  logic             freeze;
  logic [FWD_W-1:0] fwda;
  logic [FWD_W-1:0] fwdb;
  logic             mem_err;

  modport master (
    output rs, rt, id_use_rs, id_use_rt, id_flushed,
    output ewreg, em2reg, ern, mwreg, mm2reg, mrn,
    output branch_taken, mem_req, mem_ready,
    input  wpcir, flush, bubble, freeze, fwda, fwdb, mem_err
  );

  modport slave (
    input  rs, rt, id_use_rs, id_use_rt, id_flushed,
    input  ewreg, em2reg, ern, mwreg, mm2reg, mrn,
    input  branch_taken, mem_req, mem_ready,
    output wpcir, flush, bubble, freeze, fwda, fwdb, mem_err
  );

endinterface : pipe_hazard_ctrl_if

// File: rtl/pipe_fwd_sel.sv
// Combinational forwarding select for one ID-stage source operand.
// Ports: src (operand index), EX producer (ewreg/em2reg/ern),
//        MEM producer (mwreg/mm2reg/mrn), fwd_c (select code out).
module pipe_fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [REG_W-1:0] ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [REG_W-1:0] mrn,
  output logic [FWD_W-1:0] fwd_c
);

  logic src_nz;
  logic ex_hit;
  logic mem_hit;

  // r0 is hardwired to zero, so it never takes a forwarded value
  assign src_nz  = (src != REG_W'(0));
  assign ex_hit  = src_nz && (ern == src);
  assign mem_hit = src_nz && (mrn == src);

  // Youngest producer wins; a load still in EX has no data yet
  always_comb begin
    fwd_c = FWD_REG;
    if (ewreg && !em2reg && ex_hit) begin
      fwd_c = FWD_EXALU;
    end else if (mwreg && !mm2reg && mem_hit) begin
      fwd_c = FWD_MEMALU;
    end else if (mwreg && mm2reg && mem_hit) begin
      fwd_c = FWD_MEMLD;
    end
  end

endmodule : pipe_fwd_sel

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: PC/IF-ID write enable, IF/ID
// flush, ID/EX bubble, whole-pipe freeze on slow data memory, ID forwarding
// selects, and a memory-wait FSM with timeout into a sticky error state.
// Ports:
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   bus (slave)   : stage info in; wpcir/flush/bubble/freeze/fwda/fwdb/mem_err out
//   ldstall_cnt, memstall_cnt : stall counters, only with PIPE_HAZARD_PERF_EN
// Parameters: TIMEOUT (max MEMWAIT cycles, >=2), CNT_W (2**CNT_W > TIMEOUT).
// Optional build macro: PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clock,
  input  logic        resetn,
  pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] ldstall_cnt,
  output logic [31:0] memstall_cnt
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [FWD_W-1:0] fwda_c;
  logic [FWD_W-1:0] fwdb_c;
  logic             ms_c;
  logic             ldh_c;

  pipe_fwd_sel u_fwd_a (
    .src    (bus.rs),
    .ewreg  (bus.ewreg),
    .em2reg (bus.em2reg),
    .ern    (bus.ern),
    .mwreg  (bus.mwreg),
    .mm2reg (bus.mm2reg),
    .mrn    (bus.mrn),
    .fwd_c  (fwda_c)
  );

  pipe_fwd_sel u_fwd_b (
    .src    (bus.rt),
    .ewreg  (bus.ewreg),
    .em2reg (bus.em2reg),
    .ern    (bus.ern),
    .mwreg  (bus.mwreg),
    .mm2reg (bus.mm2reg),
    .mrn    (bus.mrn),
    .fwd_c  (fwdb_c)
  );

  // State and wait-counter registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: wait for mem_ready, give up after TIMEOUT wait cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_d = MEMWAIT;
          cnt_d   = '0;
        end
      end
      MEMWAIT: begin
        if (bus.mem_ready) begin
          state_d = RUN;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  // Stall conditions; the memory stall covers the first request cycle itself
  always_comb begin
    ms_c  = ((state_q == RUN) && bus.mem_req && !bus.mem_ready) ||
            ((state_q == MEMWAIT) && !bus.mem_ready) ||
            (state_q == ERR);
    ldh_c = bus.ewreg && bus.em2reg && (bus.ern != REG_W'(0)) && !bus.id_flushed &&
            ((bus.id_use_rs && (bus.ern == bus.rs)) ||
             (bus.id_use_rt && (bus.ern == bus.rt)));
  end

  // Outputs: forced to the idle pattern while reset is held
  always_comb begin
    bus.wpcir   = 1'b1;
    bus.flush   = 1'b0;
    bus.bubble  = 1'b0;
    bus.freeze  = 1'b0;
    bus.fwda    = FWD_REG;
    bus.fwdb    = FWD_REG;
    bus.mem_err = 1'b0;
    if (resetn) begin
      bus.fwda    = fwda_c;
      bus.fwdb    = fwdb_c;
      bus.mem_err = (state_q == ERR);
      if (ms_c) begin
        bus.freeze = 1'b1;
        bus.wpcir  = 1'b0;
      end else if (ldh_c) begin
        // A pending branch is dropped; it resolves again once the stall clears
        bus.wpcir  = 1'b0;
        bus.bubble = 1'b1;
      end else begin
        bus.flush  = bus.branch_taken;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  // Stall event counters, free-running modulo 2^32
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ldstall_cnt  <= '0;
      memstall_cnt <= '0;
    end else begin
      if (ldh_c && !ms_c) ldstall_cnt <= ldstall_cnt + 32'd1;
      if (ms_c)           memstall_cnt <= memstall_cnt + 32'd1;
    end
  end
`endif

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=3).
module tb_pipe_hazard_ctrl;

  logic clock = 1'b0;
  logic resetn;
  int   tests  = 0;
  int   failed = 0;

  pipe_hazard_ctrl_if bus ();

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] ldstall_cnt;
  logic [31:0] memstall_cnt;
`endif

  pipe_hazard_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (3)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .ldstall_cnt  (ldstall_cnt),
    .memstall_cnt (memstall_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic clear_inputs();
    bus.rs = 5'd0; bus.rt = 5'd0;
    bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0; bus.id_flushed = 1'b0;
    bus.ewreg = 1'b0; bus.em2reg = 1'b0; bus.ern = 5'd0;
    bus.mwreg = 1'b0; bus.mm2reg = 1'b0; bus.mrn = 5'd0;
    bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  // Advance one clock; inputs change just after the edge, checks follow #1 later
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    bus.mem_req = 1'b1; bus.branch_taken = 1'b1;
    bus.ewreg = 1'b1; bus.ern = 5'd3; bus.rs = 5'd3; bus.rt = 5'd3;
    #2;
    tests++; if (bus.wpcir !== 1'b1) begin failed++; $display("FAIL reset_wpcir got %b exp 1", bus.wpcir); end
    tests++; if (bus.freeze !== 1'b0) begin failed++; $display("FAIL reset_freeze got %b exp 0", bus.freeze); end
    tests++; if (bus.flush !== 1'b0) begin failed++; $display("FAIL reset_flush got %b exp 0", bus.flush); end
    tests++; if (bus.bubble !== 1'b0) begin failed++; $display("FAIL reset_bubble got %b exp 0", bus.bubble); end
    tests++; if (bus.fwda !== 2'b00 || bus.fwdb !== 2'b00) begin failed++; $display("FAIL reset_fwd got %b/%b exp 00/00", bus.fwda, bus.fwdb); end
    tests++; if (bus.mem_err !== 1'b0) begin failed++; $display("FAIL reset_mem_err got %b exp 0", bus.mem_err); end
    tick();
    clear_inputs();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_alu_alu();
    clear_inputs();
    bus.ewreg = 1'b1; bus.em2reg = 1'b0; bus.ern = 5'd5;
    bus.rs = 5'd5; bus.rt = 5'd5; bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
    #1;
    tests++; if (bus.fwda !== 2'b01 || bus.fwdb !== 2'b01) begin failed++; $display("FAIL alu_fwd got %b/%b exp 01/01", bus.fwda, bus.fwdb); end
    tests++; if (bus.wpcir !== 1'b1 || bus.bubble !== 1'b0) begin failed++; $display("FAIL alu_wpcir got %b bubble %b exp 1/0", bus.wpcir, bus.bubble); end
    // EX beats MEM for the same register
    bus.mwreg = 1'b1; bus.mrn = 5'd5;
    #1;
    tests++; if (bus.fwda !== 2'b01) begin failed++; $display("FAIL alu_prio got %b exp 01", bus.fwda); end
    // Only MEM ALU result matches rs; rt has no producer
    bus.ern = 5'd6; bus.rt = 5'd7;
    #1;
    tests++; if (bus.fwda !== 2'b10 || bus.fwdb !== 2'b00) begin failed++; $display("FAIL memalu_fwd got %b/%b exp 10/00", bus.fwda, bus.fwdb); end
    bus.mm2reg = 1'b1;
    #1;
    tests++; if (bus.fwda !== 2'b11) begin failed++; $display("FAIL memld_fwd got %b exp 11", bus.fwda); end
    // rt matches EX ALU while rs matches MEM load
    bus.rt = 5'd6;
    #1;
    tests++; if (bus.fwda !== 2'b11 || bus.fwdb !== 2'b01) begin failed++; $display("FAIL mixed_fwd got %b/%b exp 11/01", bus.fwda, bus.fwdb); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd8;
    bus.rs = 5'd3; bus.rt = 5'd8; bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
    #1;
    tests++; if (bus.wpcir !== 1'b0 || bus.bubble !== 1'b1) begin failed++; $display("FAIL ldh_stall wpcir %b bubble %b exp 0/1", bus.wpcir, bus.bubble); end
    tests++; if (bus.fwdb !== 2'b00) begin failed++; $display("FAIL ldh_no_fwd got %b exp 00", bus.fwdb); end
    tick();
    // Load has advanced to MEM, bubble sits in EX
    bus.ewreg = 1'b0; bus.em2reg = 1'b0; bus.ern = 5'd0;
    bus.mwreg = 1'b1; bus.mm2reg = 1'b1; bus.mrn = 5'd8;
    #1;
    tests++; if (bus.wpcir !== 1'b1 || bus.bubble !== 1'b0) begin failed++; $display("FAIL ldh_one_cycle wpcir %b bubble %b exp 1/0", bus.wpcir, bus.bubble); end
    tests++; if (bus.fwdb !== 2'b11) begin failed++; $display("FAIL ldh_memld got %b exp 11", bus.fwdb); end
    tick();
    // Operand not actually read, or ID squashed: no stall
    clear_inputs();
    bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd8; bus.rt = 5'd8;
    #1;
    tests++; if (bus.bubble !== 1'b0 || bus.wpcir !== 1'b1) begin failed++; $display("FAIL ldh_unused bubble %b wpcir %b exp 0/1", bus.bubble, bus.wpcir); end
    bus.id_use_rt = 1'b1; bus.id_flushed = 1'b1;
    #1;
    tests++; if (bus.bubble !== 1'b0 || bus.wpcir !== 1'b1) begin failed++; $display("FAIL ldh_flushed bubble %b wpcir %b exp 0/1", bus.bubble, bus.wpcir); end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    bus.branch_taken = 1'b1;
    #1;
    tests++; if (bus.flush !== 1'b1 || bus.wpcir !== 1'b1) begin failed++; $display("FAIL br_flush got %b wpcir %b exp 1/1", bus.flush, bus.wpcir); end
    tick();
    bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd9; bus.rs = 5'd9; bus.id_use_rs = 1'b1;
    #1;
    tests++; if (bus.flush !== 1'b0 || bus.bubble !== 1'b1) begin failed++; $display("FAIL br_in_ldh flush %b bubble %b exp 0/1", bus.flush, bus.bubble); end
    tick();
    bus.ewreg = 1'b0; bus.em2reg = 1'b0; bus.ern = 5'd0;
    bus.mwreg = 1'b1; bus.mm2reg = 1'b1; bus.mrn = 5'd9;
    #1;
    tests++; if (bus.flush !== 1'b1 || bus.bubble !== 1'b0) begin failed++; $display("FAIL br_after_ldh flush %b bubble %b exp 1/0", bus.flush, bus.bubble); end
    tick();
  endtask

  task automatic test_mem_stall();
    clear_inputs();
    // Ready on the first request cycle: no stall at all
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    #1;
    tests++; if (bus.freeze !== 1'b0 || bus.wpcir !== 1'b1) begin failed++; $display("FAIL mem_zero freeze %b wpcir %b exp 0/1", bus.freeze, bus.wpcir); end
    tick();
    bus.mem_ready = 1'b0;
    // Freeze asserted in the request cycle itself, load-use and branch suppressed
    bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd4; bus.rs = 5'd4; bus.id_use_rs = 1'b1;
    bus.branch_taken = 1'b1;
    #1;
    tests++; if (bus.freeze !== 1'b1 || bus.wpcir !== 1'b0 || bus.bubble !== 1'b0 || bus.flush !== 1'b0) begin
      failed++; $display("FAIL mem_c1 fz %b wp %b bb %b fl %b exp 1/0/0/0", bus.freeze, bus.wpcir, bus.bubble, bus.flush); end
    tick();
    tests++; if (bus.freeze !== 1'b1 || bus.wpcir !== 1'b0) begin failed++; $display("FAIL mem_c2 freeze %b wpcir %b exp 1/0", bus.freeze, bus.wpcir); end
    tick();
    tests++; if (bus.freeze !== 1'b1 || bus.wpcir !== 1'b0) begin failed++; $display("FAIL mem_c3 freeze %b wpcir %b exp 1/0", bus.freeze, bus.wpcir); end
    tick();
    clear_inputs();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    #1;
    tests++; if (bus.freeze !== 1'b0 || bus.wpcir !== 1'b1) begin failed++; $display("FAIL mem_c4 freeze %b wpcir %b exp 0/1", bus.freeze, bus.wpcir); end
    tick();
    // Back in RUN: an idle cycle is clean and a fresh miss freezes at once
    clear_inputs();
    #1;
    tests++; if (bus.freeze !== 1'b0 || bus.mem_err !== 1'b0) begin failed++; $display("FAIL mem_run freeze %b err %b exp 0/0", bus.freeze, bus.mem_err); end
    bus.mem_req = 1'b1;
    #1;
    tests++; if (bus.freeze !== 1'b1) begin failed++; $display("FAIL mem_rerun freeze %b exp 1", bus.freeze); end
    bus.mem_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_ready_vs_timeout();
    clear_inputs();
    bus.mem_req = 1'b1;
    tick();
    tick();
    tick();
    tick();
    // Last MEMWAIT cycle before timeout: ready wins
    bus.mem_ready = 1'b1;
    #1;
    tests++; if (bus.freeze !== 1'b0 || bus.mem_err !== 1'b0) begin failed++; $display("FAIL rdy_last freeze %b err %b exp 0/0", bus.freeze, bus.mem_err); end
    tick();
    clear_inputs();
    #1;
    tests++; if (bus.mem_err !== 1'b0 || bus.freeze !== 1'b0) begin failed++; $display("FAIL rdy_after err %b freeze %b exp 0/0", bus.mem_err, bus.freeze); end
    tick();
  endtask

  task automatic test_timeout();
    clear_inputs();
    bus.mem_req = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.mem_err !== 1'b0 || bus.freeze !== 1'b1) begin failed++; $display("FAIL tmo_wait%0d err %b freeze %b exp 0/1", i, bus.mem_err, bus.freeze); end
      tick();
    end
    tests++; if (bus.mem_err !== 1'b1 || bus.freeze !== 1'b1) begin failed++; $display("FAIL tmo_err err %b freeze %b exp 1/1", bus.mem_err, bus.freeze); end
    // ERR ignores ready and lack of requests
    bus.mem_req = 1'b0; bus.mem_ready = 1'b1;
    tick();
    tick();
    tests++; if (bus.mem_err !== 1'b1 || bus.freeze !== 1'b1 || bus.wpcir !== 1'b0) begin
      failed++; $display("FAIL tmo_sticky err %b fz %b wp %b exp 1/1/0", bus.mem_err, bus.freeze, bus.wpcir); end
    clear_inputs();
    #2;
    resetn = 1'b0;
    #1;
    tests++; if (bus.mem_err !== 1'b0 || bus.freeze !== 1'b0) begin failed++; $display("FAIL tmo_rst err %b freeze %b exp 0/0", bus.mem_err, bus.freeze); end
    tick();
    resetn = 1'b1;
    tick();
    tests++; if (bus.mem_err !== 1'b0 || bus.freeze !== 1'b0 || bus.wpcir !== 1'b1) begin
      failed++; $display("FAIL tmo_run err %b fz %b wp %b exp 0/0/1", bus.mem_err, bus.freeze, bus.wpcir); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    clear_inputs();
    bus.mem_req = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    tests++; if (bus.freeze !== 1'b0 || bus.wpcir !== 1'b1) begin failed++; $display("FAIL wrst_hold freeze %b wpcir %b exp 0/1", bus.freeze, bus.wpcir); end
    tick();
    bus.mem_ready = 1'b1;
    resetn = 1'b1;
    #1;
    // In RUN again, so ready with request means no stall
    tests++; if (bus.freeze !== 1'b0) begin failed++; $display("FAIL wrst_run freeze %b exp 0", bus.freeze); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd0;
    bus.rs = 5'd0; bus.id_use_rs = 1'b1;
    #1;
    tests++; if (bus.bubble !== 1'b0 || bus.wpcir !== 1'b1 || bus.fwda !== 2'b00) begin
      failed++; $display("FAIL zero_ld bb %b wp %b fwda %b exp 0/1/00", bus.bubble, bus.wpcir, bus.fwda); end
    bus.em2reg = 1'b0; bus.mwreg = 1'b1; bus.mm2reg = 1'b1; bus.mrn = 5'd0; bus.rt = 5'd0;
    #1;
    tests++; if (bus.fwda !== 2'b00 || bus.fwdb !== 2'b00) begin failed++; $display("FAIL zero_fwd got %b/%b exp 00/00", bus.fwda, bus.fwdb); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_alu();
    test_load_use();
    test_branch();
    test_mem_stall();
    test_ready_vs_timeout();
    test_timeout();
    test_reset_in_wait();
    test_zero_reg();
`ifdef PIPE_HAZARD_PERF_EN
    $display("[TB] perf ldstall=%0d memstall=%0d", ldstall_cnt, memstall_cnt);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage pipeline.
- Generates the IF/ID and PC write enable (wpcir) and the IF/ID flush request.
- Generates the ID/EX bubble insert, the whole-pipe freeze for slow data memory, and the ID-stage forwarding selects.
- Holds a memory-wait FSM with a timeout and a sticky error flag.

Parameters:
- TIMEOUT, 16, max consecutive MEMWAIT cycles before error (>=2).
- CNT_W, 5, width of the wait counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- rs  in  5  ID-stage source register A.
- rt  in  5  ID-stage source register B.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_flushed  in  1  ID instruction is squashed (IF/ID flush_out).
- ewreg  in  1  EX-stage instruction writes a register.
- em2reg  in  1  EX-stage instruction is a load.
- ern  in  5  EX-stage destination register.
- mwreg  in  1  MEM-stage instruction writes a register.
- mm2reg  in  1  MEM-stage instruction is a load.
- mrn  in  5  MEM-stage destination register.
- branch_taken  in  1  ID resolved a taken branch or jump.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes this cycle.
- wpcir  out  1  PC and IF/ID write enable.
- flush  out  1  squash the instruction entering IF/ID.
- bubble  out  1  load NOP into ID/EX.
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwda  out  2  rs operand select.
- fwdb  out  2  rt operand select.
- mem_err  out  1  sticky memory timeout flag.

Behaviour:
- Reset: asynchronous, active-low. State RUN, wait counter 0, mem_err 0. While resetn=0 all outputs are driven: wpcir=1, flush=0, bubble=0, freeze=0, fwda=fwdb=00, mem_err=0.
- Forwarding (combinational; shown for fwda/rs, identical for fwdb/rt). Register 0 never matches. Priority order:
  - 01 if ewreg & !em2reg & ern==rs (EX ALU result);
  - else 10 if mwreg & !mm2reg & mrn==rs (MEM ALU result);
  - else 11 if mwreg & mm2reg & mrn==rs (MEM load data);
  - else 00 (register file).
  - A load in EX never forwards; it causes a load-use stall instead.
- Load-use hazard: ldh = ewreg & em2reg & ern!=0 & !id_flushed & ((id_use_rs & ern==rs) | (id_use_rt & ern==rt)).
- FSM states: RUN, MEMWAIT, ERR.
  - RUN: if mem_req & !mem_ready, go to MEMWAIT and clear the counter; otherwise stay.
  - MEMWAIT: if mem_ready, go to RUN. Else if counter == TIMEOUT-1, go to ERR. Else increment the counter.
  - ERR: stays in ERR until reset; mem_err=1.
- Memory stall (ms): ms = (RUN & mem_req & !mem_ready) | (MEMWAIT & !mem_ready) | ERR. The freeze starts in the same cycle as the request, with no added latency.
- Output priority (combinational):
  1. ms: freeze=1, wpcir=0, bubble=0, flush=0.
  2. else ldh: wpcir=0, bubble=1, flush=0. branch_taken is ignored; the branch re-resolves on the next cycle.
  3. else: wpcir=1, bubble=0, flush=branch_taken.
- Boundary conditions:
  - A load-use stall lasts exactly 1 cycle.
  - mem_ready arriving on the first request cycle gives zero stall.
  - mem_ready and timeout in the same cycle: mem_ready wins.
  - Asserting resetn=0 mid-MEMWAIT or in ERR returns the FSM to RUN immediately.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined:
  - Adds outputs ldstall_cnt[31:0] and memstall_cnt[31:0].
  - ldstall_cnt increments on each ldh & !ms cycle.
  - memstall_cnt increments on each ms cycle.
  - Both reset asynchronously to 0 and wrap modulo 2^32.
- When undefined: the ports and counters are absent, with no change to other behaviour.

Decomposition:
- Shared package pipe_pkg holds:
  - the forwarding-select constants FWD_REG=2'b00, FWD_EXALU=2'b01, FWD_MEMALU=2'b10, FWD_MEMLD=2'b11;
  - the FSM state typedef (RUN, MEMWAIT, ERR).
- One sub-module, pipe_fwd_sel: pure combinational forwarding for one operand, instantiated twice (rs, rt).

Test Plan:
- ALU-ALU dependency: EX ewreg=1, em2reg=0, ern=5; ID rs=5, rt=5 -> fwda=01, fwdb=01, wpcir=1.
- Load-use: EX em2reg=1, ern=8; ID rt=8, id_use_rt=1 -> one cycle wpcir=0, bubble=1; next cycle fwdb=11, wpcir=1.
- Branch taken with no hazard -> flush=1, wpcir=1. Same branch during a load-use stall -> flush=0, then flush=1 on the following cycle.
- mem_req=1 with mem_ready low for 3 cycles -> freeze=1 for 3 cycles, wpcir=0; cycle 4 with mem_ready=1 -> freeze=0, state RUN.
- TIMEOUT=4, mem_ready never asserts -> ERR entered after 4 wait cycles; mem_err=1 and freeze=1 persist; resetn pulse -> mem_err=0, state RUN.
- ern=0 with ewreg=1, em2reg=1 and rs=0 -> no stall, fwda=00.
